// File: rtl/pp_buf_pkg.sv
// Shared types and constants for the ping-pong buffer read side.
// Holds the reader FSM state type, the output FIFO geometry and the bank-index type.
package pp_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rdState_e;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTRW  = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNTW  = FIFO_PTRW + 1;

    typedef logic bank_t;

endpackage

// File: rtl/pp_rd_fifo.sv
// Small synchronous FIFO that buffers RAM read words ahead of the stream port.
// The caller only writes when space is guaranteed and only reads when count is non-zero.
module pp_rd_fifo
    import pp_buf_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic [FIFO_CNTW-1:0] count_o
);

    logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_PTRW-1:0] wrPtr_q;
    logic [FIFO_PTRW-1:0] rdPtr_q;
    logic [FIFO_CNTW-1:0] count_q;
    logic [FIFO_CNTW-1:0] count_d;

    assign count_d = count_q + FIFO_CNTW'(wr_en_i) - FIFO_CNTW'(rd_en_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_i) begin
                wrPtr_q <= wrPtr_q + FIFO_PTRW'(1);
            end
            if (rd_en_i) begin
                rdPtr_q <= rdPtr_q + FIFO_PTRW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: its contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wrPtr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rdPtr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/pp_buf_reader.sv
// Read side of the ping-pong capture buffer: drains each full bank as one AXI4-Stream frame.
// Define PP_BUF_READER_TUSER_EN to add m_axis_tuser carrying the bank index of each beat.
module pp_buf_reader
    import pp_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDRW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            bank_full,
    output logic [1:0]            bank_release,
    output logic                  enb,
    output logic [ADDRW:0]        addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef PP_BUF_READER_TUSER_EN
    ,
    output logic                  m_axis_tuser
`endif
);

`ifdef PP_BUF_READER_TUSER_EN
    localparam int TAGW = 2;
`else
    localparam int TAGW = 1;
`endif
    localparam int                FW       = DATA_WIDTH + TAGW;
    localparam logic [ADDRW-1:0]  LAST_OFF = ADDRW'(DEPTH - 1);

    rdState_e             state_q;
    bank_t                curBank_q;
    logic [ADDRW-1:0]     offset_q;
    logic                 inflight_q;
    logic [TAGW-1:0]      pipeTag_q;

    logic                 issue;
    logic                 pop;
    logic                 lastBeat;
    logic [TAGW-1:0]      issueTag;
    logic [FIFO_CNTW-1:0] fifoCount;
    logic [FW-1:0]        fifoRdData;

    // A read may only be issued when the FIFO can absorb it plus the one still in the RAM pipe.
    assign issue    = (state_q == READ) && ((int'(fifoCount) + int'(inflight_q)) < FIFO_DEPTH);
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign lastBeat = (state_q == DRAIN) && pop && m_axis_tlast;

`ifdef PP_BUF_READER_TUSER_EN
    assign issueTag = {curBank_q, offset_q == LAST_OFF};
`else
    assign issueTag = offset_q == LAST_OFF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            curBank_q <= '0;
            offset_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bank_full[curBank_q]) begin
                        state_q  <= READ;
                        offset_q <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (offset_q == LAST_OFF) begin
                            state_q <= DRAIN;
                        end else begin
                            offset_q <= offset_q + ADDRW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (lastBeat) begin
                        state_q   <= IDLE;
                        curBank_q <= ~curBank_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tags ride alongside the RAM read latency so they land in the FIFO with their word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            pipeTag_q  <= '0;
        end else begin
            inflight_q <= issue;
            pipeTag_q  <= issueTag;
        end
    end

    pp_rd_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i ({pipeTag_q, dob}),
        .rd_en_i   (pop),
        .rd_data_o (fifoRdData),
        .count_o   (fifoCount)
    );

    assign enb           = issue;
    assign addrb         = {curBank_q, offset_q};
    assign bank_release  = lastBeat ? (2'b01 << curBank_q) : 2'b00;
    assign m_axis_tvalid = fifoCount != '0;
    assign m_axis_tdata  = m_axis_tvalid ? fifoRdData[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid && fifoRdData[DATA_WIDTH];
`ifdef PP_BUF_READER_TUSER_EN
    assign m_axis_tuser  = m_axis_tvalid && fifoRdData[DATA_WIDTH+1];
`endif

endmodule

// File: tb/tb_pp_buf_reader.sv
// Self-checking bench for pp_buf_reader: a cycle table for reset and frame start, then
// frame-level sequences for back-to-back banks, mid-frame reset and random backpressure.
module tb_pp_buf_reader;

    typedef struct {
        logic        rst;
        logic [1:0]  bf;
        logic        tready;
        logic        expEnb;
        logic [4:0]  expAddr;
        logic        expValid;
        logic [31:0] expData;
        logic        expLast;
        logic [1:0]  expRel;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bankFull;
    logic [1:0]  bankRelease;
    logic        enb;
    logic [4:0]  addrb;
    logic [31:0] dob;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef PP_BUF_READER_TUSER_EN
    logic        tuser;
`endif

    logic [31:0] ram [32];
    int          checks   = 0;
    int          failures = 0;
    vec_t        vecs [10];

    always #5 clk = ~clk;

    // Registered-read RAM model: data appears the cycle after enb.
    always @(posedge clk) begin
        if (enb) dob <= ram[addrb];
    end

    pp_buf_reader #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .ADDRW      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bank_full     (bankFull),
        .bank_release  (bankRelease),
        .enb           (enb),
        .addrb         (addrb),
        .dob           (dob),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
`ifdef PP_BUF_READER_TUSER_EN
        ,
        .m_axis_tuser  (tuser)
`endif
    );

    function automatic logic [31:0] expWord(input logic bank, input int idx);
        return bank ? (32'h100 + 32'(idx)) : 32'(idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one cycle, drive this cycle's inputs, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic [1:0] bf, input logic rdy);
        @(posedge clk);
        #1;
        rst      = r;
        bankFull = bf;
        tready   = rdy;
        #1;
    endtask

    task automatic runFrames(input int nFrames, input bit randomReady, input bit checkGap,
                             input bit refill, input int startBeat, input int startIssue);
        int          beatIdx    = startBeat;
        int          issueIdx   = startIssue;
        int          framesDone = 0;
        int          lastRel    = -1;
        logic        beatBank   = 1'b0;
        logic        issueBank  = 1'b0;
        logic        prevStall  = 1'b0;
        logic [31:0] prevData   = '0;
        logic [1:0]  refillMask = 2'b00;
        logic [4:0]  expAddr;
        for (int cyc = 0; cyc < 3000 && framesDone < nFrames; cyc++) begin
            @(posedge clk);
            #1;
            tready     = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            bankFull   = bankFull | refillMask;
            refillMask = 2'b00;
            #1;
            if (enb) begin
                expAddr = {issueBank, 4'(issueIdx)};
                checkOutput("addrb", 32'(addrb), 32'(expAddr));
                issueIdx++;
                if (issueIdx == 16) begin
                    issueIdx  = 0;
                    issueBank = ~issueBank;
                end
            end
            if (prevStall) begin
                checkOutput("tvalid_hold", 32'(tvalid), 32'd1);
                checkOutput("tdata_hold", tdata, prevData);
            end
            if (tvalid && tready) begin
                if (checkGap && beatIdx == 0 && lastRel >= 0)
                    checkOutput("frame_gap", 32'(cyc - lastRel), 32'd4);
                checkOutput("tdata", tdata, expWord(beatBank, beatIdx));
                checkOutput("tlast", 32'(tlast), 32'(beatIdx == 15));
                checkOutput("release", 32'(bankRelease),
                            (beatIdx == 15) ? 32'(2'b01 << beatBank) : 32'd0);
`ifdef PP_BUF_READER_TUSER_EN
                checkOutput("tuser", 32'(tuser), 32'(beatBank));
`endif
                if (beatIdx == 15) begin
                    lastRel = cyc;
                    framesDone++;
                    bankFull[beatBank] = 1'b0;
                    if (refill) refillMask[beatBank] = 1'b1;
                    beatBank = ~beatBank;
                    beatIdx  = 0;
                end else begin
                    beatIdx++;
                end
            end else begin
                checkOutput("release_idle", 32'(bankRelease), 32'd0);
            end
            prevStall = tvalid && !tready;
            prevData  = tdata;
        end
        checkOutput("frames_done", 32'(framesDone), 32'(nFrames));
    endtask

    initial begin
        int beats;
        for (int i = 0; i < 32; i++) ram[i] = (i < 16) ? 32'(i) : 32'h100 + 32'(i - 16);

        // Reset, bank 1 alone is ignored, then both banks full: first tvalid 3 cycles later.
        vecs[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[1] = '{1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[2] = '{1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[3] = '{1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[4] = '{1'b0, 2'b10, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[5] = '{1'b0, 2'b11, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[6] = '{1'b0, 2'b11, 1'b1, 1'b1, 5'h00, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[7] = '{1'b0, 2'b11, 1'b1, 1'b1, 5'h01, 1'b0, 32'h0, 1'b0, 2'b00};
        vecs[8] = '{1'b0, 2'b11, 1'b1, 1'b1, 5'h02, 1'b1, 32'h0, 1'b0, 2'b00};
        vecs[9] = '{1'b0, 2'b11, 1'b1, 1'b1, 5'h03, 1'b1, 32'h1, 1'b0, 2'b00};

        rst      = 1'b1;
        bankFull = 2'b00;
        tready   = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].bf, vecs[i].tready);
            checkOutput($sformatf("vec%0d_enb", i), 32'(enb), 32'(vecs[i].expEnb));
            checkOutput($sformatf("vec%0d_addrb", i), 32'(addrb), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_tdata", i), tdata, vecs[i].expData);
            checkOutput($sformatf("vec%0d_tlast", i), 32'(tlast), 32'(vecs[i].expLast));
            checkOutput($sformatf("vec%0d_release", i), 32'(bankRelease), 32'(vecs[i].expRel));
        end

        $display("[TB] back-to-back banks 0 then 1");
        runFrames(2, 1'b0, 1'b1, 1'b0, 2, 4);
        applyStimulus(1'b0, 2'b00, 1'b1);
        checkOutput("idle_after_both_enb", 32'(enb), 32'd0);
        checkOutput("idle_after_both_tvalid", 32'(tvalid), 32'd0);

        $display("[TB] reset in the middle of a bank 0 frame");
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b1);
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 5; cyc++) begin
            @(posedge clk);
            #2;
            if (tvalid && tready) begin
                checkOutput("pre_rst_tdata", tdata, 32'(beats));
                beats++;
            end
        end
        checkOutput("pre_rst_beats", 32'(beats), 32'd5);
        applyStimulus(1'b1, 2'b01, 1'b1);
        checkOutput("rst_cycle_release", 32'(bankRelease), 32'd0);
        applyStimulus(1'b0, 2'b01, 1'b1);
        checkOutput("post_rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("post_rst_tdata", tdata, 32'd0);
        checkOutput("post_rst_tlast", 32'(tlast), 32'd0);
        checkOutput("post_rst_enb", 32'(enb), 32'd0);
        checkOutput("post_rst_addrb", 32'(addrb), 32'd0);
        checkOutput("post_rst_release", 32'(bankRelease), 32'd0);
        runFrames(1, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("[TB] random backpressure over four frames");
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b1);
        runFrames(4, 1'b1, 1'b0, 1'b1, 0, 0);
        applyStimulus(1'b1, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
